// File: rtl/pic_command_registers.sv
// Purpose: 8259 ICW/OCW command register stage: runs the init sequence, holds config, emits command pulses.
// Latency: a strobe rising edge takes effect at the next clk edge; pulses are high for the one cycle after it.
// Backpressure: none; every write strobe edge is accepted, and writes that arrive in the wrong state are dropped.
//
// Ports:
//   clk, reset (sync, active-low)        clock / reset
//   internal_bus[7:0]                    data byte from the control bus
//   write_ICW_1 .. write_OCW3            level write strobes (acted on at rising edge)
//   read, A1, irr_in, isr_in             CPU read qualifiers and read-back sources
//   init_done, ltim, sngl, ic4, aeoi     init status / latched ICW bits
//   vector_base[4:0], mask[7:0]          ICW2[7:3] and OCW1 mask
//   special_mask, read_isr, rotate_aeoi  OCW-derived mode flags
//   eoi_ns/eoi_sp/set_prio/poll_pulse    one-cycle commands; cmd_level[2:0] qualifies them
//   read_data[7:0]                       combinational read-back byte (00 when not reading)
module pic_command_registers (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] internal_bus,
  input  logic       write_ICW_1,
  input  logic       write_ICW2,
  input  logic       write_ICW4,
  input  logic       write_OCW1,
  input  logic       write_OCW2,
  input  logic       write_OCW3,
  input  logic       read,
  input  logic       A1,
  input  logic [7:0] irr_in,
  input  logic [7:0] isr_in,
  output logic       init_done,
  output logic       ltim,
  output logic       sngl,
  output logic       ic4,
  output logic       aeoi,
  output logic [4:0] vector_base,
  output logic [7:0] mask,
  output logic       special_mask,
  output logic       read_isr,
  output logic       rotate_aeoi,
  output logic       eoi_ns_pulse,
  output logic       eoi_sp_pulse,
  output logic       set_prio_pulse,
  output logic       poll_pulse,
  output logic [2:0] cmd_level,
  output logic [7:0] read_data
);

  typedef enum logic [1:0] {
    UNINIT    = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW4 = 2'd2,
    READY     = 2'd3
  } state_t;

  state_t     state_q, state_d;

  // Strobe history, order: ICW1, ICW2, ICW4, OCW1, OCW2, OCW3
  logic [5:0] prev_q, prev_d;
  logic [5:0] strobes;
  logic [5:0] edges;

  logic       ltim_q, ltim_d;
  logic       sngl_q, sngl_d;
  logic       ic4_q, ic4_d;
  logic       aeoi_q, aeoi_d;
  logic [4:0] vector_base_q, vector_base_d;
  logic [7:0] mask_q, mask_d;
  logic       special_mask_q, special_mask_d;
  logic       read_isr_q, read_isr_d;
  logic       rotate_aeoi_q, rotate_aeoi_d;
  logic       eoi_ns_q, eoi_ns_d;
  logic       eoi_sp_q, eoi_sp_d;
  logic       set_prio_q, set_prio_d;
  logic       poll_q, poll_d;
  logic [2:0] cmd_level_q, cmd_level_d;

  assign strobes = {write_OCW3, write_OCW2, write_OCW1, write_ICW4, write_ICW2, write_ICW_1};
  assign edges   = strobes & ~prev_q;

  always_comb begin
    state_d        = state_q;
    prev_d         = strobes;
    ltim_d         = ltim_q;
    sngl_d         = sngl_q;
    ic4_d          = ic4_q;
    aeoi_d         = aeoi_q;
    vector_base_d  = vector_base_q;
    mask_d         = mask_q;
    special_mask_d = special_mask_q;
    read_isr_d     = read_isr_q;
    rotate_aeoi_d  = rotate_aeoi_q;
    eoi_ns_d       = 1'b0;
    eoi_sp_d       = 1'b0;
    set_prio_d     = 1'b0;
    poll_d         = 1'b0;
    cmd_level_d    = cmd_level_q;

    if (edges[0]) begin
      // ICW1 restarts initialization and wins over any other strobe this cycle
      ltim_d         = internal_bus[3];
      sngl_d         = internal_bus[1];
      ic4_d          = internal_bus[0];
      mask_d         = 8'h00;
      special_mask_d = 1'b0;
      read_isr_d     = 1'b0;
      rotate_aeoi_d  = 1'b0;
      aeoi_d         = 1'b0;
      state_d        = WAIT_ICW2;
    end else begin
      unique case (state_q)
        WAIT_ICW2: begin
          if (edges[1]) begin
            vector_base_d = internal_bus[7:3];
            state_d       = ic4_q ? WAIT_ICW4 : READY;
          end
        end
        WAIT_ICW4: begin
          if (edges[2]) begin
            aeoi_d  = internal_bus[1];
            state_d = READY;
          end
        end
        READY: begin
          if (edges[3]) begin
            mask_d = internal_bus;
          end
          if (edges[4]) begin
            // Decoded on R, SL, EOI
            unique case (internal_bus[7:5])
              3'b001, 3'b101: eoi_ns_d = 1'b1;
              3'b011, 3'b111: begin
                eoi_sp_d    = 1'b1;
                cmd_level_d = internal_bus[2:0];
              end
              3'b110: begin
                set_prio_d  = 1'b1;
                cmd_level_d = internal_bus[2:0];
              end
              3'b100: rotate_aeoi_d = 1'b1;
              3'b000: rotate_aeoi_d = 1'b0;
              default: ;
            endcase
          end
          if (edges[5]) begin
            if (internal_bus[6]) special_mask_d = internal_bus[5];
            if (internal_bus[1]) read_isr_d     = internal_bus[0];
            if (internal_bus[2]) poll_d         = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= UNINIT;
      prev_q         <= 6'b0;
      ltim_q         <= 1'b0;
      sngl_q         <= 1'b0;
      ic4_q          <= 1'b0;
      aeoi_q         <= 1'b0;
      vector_base_q  <= 5'b0;
      mask_q         <= 8'h00;
      special_mask_q <= 1'b0;
      read_isr_q     <= 1'b0;
      rotate_aeoi_q  <= 1'b0;
      eoi_ns_q       <= 1'b0;
      eoi_sp_q       <= 1'b0;
      set_prio_q     <= 1'b0;
      poll_q         <= 1'b0;
      cmd_level_q    <= 3'b0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      ltim_q         <= ltim_d;
      sngl_q         <= sngl_d;
      ic4_q          <= ic4_d;
      aeoi_q         <= aeoi_d;
      vector_base_q  <= vector_base_d;
      mask_q         <= mask_d;
      special_mask_q <= special_mask_d;
      read_isr_q     <= read_isr_d;
      rotate_aeoi_q  <= rotate_aeoi_d;
      eoi_ns_q       <= eoi_ns_d;
      eoi_sp_q       <= eoi_sp_d;
      set_prio_q     <= set_prio_d;
      poll_q         <= poll_d;
      cmd_level_q    <= cmd_level_d;
    end
  end

  assign init_done      = (state_q == READY);
  assign ltim           = ltim_q;
  assign sngl           = sngl_q;
  assign ic4            = ic4_q;
  assign aeoi           = aeoi_q;
  assign vector_base    = vector_base_q;
  assign mask           = mask_q;
  assign special_mask   = special_mask_q;
  assign read_isr       = read_isr_q;
  assign rotate_aeoi    = rotate_aeoi_q;
  assign eoi_ns_pulse   = eoi_ns_q;
  assign eoi_sp_pulse   = eoi_sp_q;
  assign set_prio_pulse = set_prio_q;
  assign poll_pulse     = poll_q;
  assign cmd_level      = cmd_level_q;

  always_comb begin
    read_data = 8'h00;
    if (read) begin
      if (A1)            read_data = mask_q;
      else if (read_isr_q) read_data = isr_in;
      else               read_data = irr_in;
    end
  end

endmodule

// File: tb/tb_pic_command_registers.sv
// Purpose: directed self-checking bench for pic_command_registers.
// Latency: inputs change 1ns after a rising edge; outputs are checked 1ns after the following edge.
// Backpressure: not applicable; strobes are driven as level pulses.
module tb_pic_command_registers;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] internal_bus;
  logic       write_ICW_1, write_ICW2, write_ICW4;
  logic       write_OCW1, write_OCW2, write_OCW3;
  logic       read, A1;
  logic [7:0] irr_in, isr_in;
  logic       init_done, ltim, sngl, ic4, aeoi;
  logic [4:0] vector_base;
  logic [7:0] mask;
  logic       special_mask, read_isr, rotate_aeoi;
  logic       eoi_ns_pulse, eoi_sp_pulse, set_prio_pulse, poll_pulse;
  logic [2:0] cmd_level;
  logic [7:0] read_data;

  int checks = 0;
  int failures = 0;
  int sp_cnt;

  localparam int S_ICW1 = 0, S_ICW2 = 1, S_ICW4 = 2, S_OCW1 = 3, S_OCW2 = 4, S_OCW3 = 5;

  always #5 clk = ~clk;

  pic_command_registers dut (
    .clk(clk), .reset(reset), .internal_bus(internal_bus),
    .write_ICW_1(write_ICW_1), .write_ICW2(write_ICW2), .write_ICW4(write_ICW4),
    .write_OCW1(write_OCW1), .write_OCW2(write_OCW2), .write_OCW3(write_OCW3),
    .read(read), .A1(A1), .irr_in(irr_in), .isr_in(isr_in),
    .init_done(init_done), .ltim(ltim), .sngl(sngl), .ic4(ic4), .aeoi(aeoi),
    .vector_base(vector_base), .mask(mask), .special_mask(special_mask),
    .read_isr(read_isr), .rotate_aeoi(rotate_aeoi),
    .eoi_ns_pulse(eoi_ns_pulse), .eoi_sp_pulse(eoi_sp_pulse),
    .set_prio_pulse(set_prio_pulse), .poll_pulse(poll_pulse),
    .cmd_level(cmd_level), .read_data(read_data)
  );

  // All registered outputs packed together: 28 bits
  function automatic logic [27:0] all_outs();
    return {init_done, ltim, sngl, ic4, aeoi, vector_base, mask, special_mask,
            read_isr, rotate_aeoi, eoi_ns_pulse, eoi_sp_pulse, set_prio_pulse,
            poll_pulse, cmd_level};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_strobe(input int sel, input logic v);
    case (sel)
      S_ICW1: write_ICW_1 = v;
      S_ICW2: write_ICW2  = v;
      S_ICW4: write_ICW4  = v;
      S_OCW1: write_OCW1  = v;
      S_OCW2: write_OCW2  = v;
      default: write_OCW3 = v;
    endcase
  endtask

  // Raise strobe, take one edge (results visible on return), then drop strobe
  // so the next edge observes pulse fall-off.
  task automatic wr(input int sel, input logic [7:0] data);
    internal_bus = data;
    set_strobe(sel, 1'b1);
    tick();
    set_strobe(sel, 1'b0);
  endtask

  initial begin
    reset = 1'b0; internal_bus = 8'h00;
    write_ICW_1 = 0; write_ICW2 = 0; write_ICW4 = 0;
    write_OCW1 = 0; write_OCW2 = 0; write_OCW3 = 0;
    read = 0; A1 = 0; irr_in = 8'h80; isr_in = 8'h04;
    tick(); tick();
    reset = 1'b1;
    tick();
    check("reset_outs", 32'(all_outs()), 32'h0);
    check("reset_rdata", 32'(read_data), 32'h0);

    wr(S_OCW1, 8'hFF); tick();
    check("ocw1_uninit_mask", 32'(mask), 32'h00);

    // ICW1=13, ICW2=20, ICW4=03
    wr(S_ICW1, 8'h13);
    check("icw1_ic4", 32'(ic4), 1);
    check("icw1_sngl", 32'(sngl), 1);
    check("icw1_ltim", 32'(ltim), 0);
    check("icw1_init0", 32'(init_done), 0);
    tick();
    wr(S_ICW2, 8'h20);
    check("icw2_vb", 32'(vector_base), 32'h04);
    check("icw2_init0", 32'(init_done), 0);
    tick();
    wr(S_ICW4, 8'h03);
    check("icw4_aeoi", 32'(aeoi), 1);
    check("icw4_init1", 32'(init_done), 1);
    tick();

    // ICW1=12 (no ICW4), ICW2=48
    wr(S_ICW1, 8'h12);
    check("icw1b_ic4", 32'(ic4), 0);
    check("icw1b_aeoi_clr", 32'(aeoi), 0);
    tick();
    wr(S_ICW2, 8'h48);
    check("icw2b_init1", 32'(init_done), 1);
    check("icw2b_vb", 32'(vector_base), 32'h09);
    tick();
    wr(S_ICW4, 8'hFF); tick();
    check("icw4_ignored_aeoi", 32'(aeoi), 0);
    check("icw4_ignored_state", 32'(init_done), 1);

    // OCW1 and read-back
    wr(S_OCW1, 8'hA5);
    check("ocw1_mask", 32'(mask), 32'hA5);
    read = 1; A1 = 1; #1;
    check("rd_mask", 32'(read_data), 32'hA5);
    A1 = 0; #1;
    check("rd_irr", 32'(read_data), 32'h80);
    read = 0; #1;
    check("rd_idle", 32'(read_data), 32'h00);
    tick();

    wr(S_OCW3, 8'h0B);
    check("ocw3_read_isr", 32'(read_isr), 1);
    check("ocw3_no_poll", 32'(poll_pulse), 0);
    read = 1; A1 = 0; #1;
    check("rd_isr", 32'(read_data), 32'h04);
    read = 0;
    tick();

    // OCW2 specific EOI, level 3
    wr(S_OCW2, 8'h63);
    check("sp_pulse_hi", 32'(eoi_sp_pulse), 1);
    check("sp_level", 32'(cmd_level), 3);
    check("sp_no_ns", 32'(eoi_ns_pulse), 0);
    tick();
    check("sp_pulse_lo", 32'(eoi_sp_pulse), 0);
    check("sp_level_hold", 32'(cmd_level), 3);

    // Held strobe yields one pulse
    sp_cnt = 0;
    internal_bus = 8'h61; write_OCW2 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      sp_cnt += int'(eoi_sp_pulse);
    end
    write_OCW2 = 0;
    tick();
    sp_cnt += int'(eoi_sp_pulse);
    check("held_one_pulse", 32'(sp_cnt), 1);
    check("held_level", 32'(cmd_level), 1);

    wr(S_OCW2, 8'h20);
    check("ns_pulse_hi", 32'(eoi_ns_pulse), 1);
    tick();
    check("ns_pulse_lo", 32'(eoi_ns_pulse), 0);

    wr(S_OCW2, 8'hC5);
    check("setprio_pulse", 32'(set_prio_pulse), 1);
    check("setprio_level", 32'(cmd_level), 5);
    tick();
    wr(S_OCW2, 8'h80); tick();
    check("rotate_set", 32'(rotate_aeoi), 1);
    wr(S_OCW2, 8'h40); tick();
    check("nop_rotate_kept", 32'(rotate_aeoi), 1);
    check("nop_level_kept", 32'(cmd_level), 5);
    wr(S_OCW3, 8'h64);
    check("poll_pulse", 32'(poll_pulse), 1);
    check("special_mask", 32'(special_mask), 1);
    tick();

    // ICW1 with simultaneous OCW1 in READY: ICW1 wins
    internal_bus = 8'h13; write_ICW_1 = 1; write_OCW1 = 1;
    tick();
    write_ICW_1 = 0; write_OCW1 = 0;
    check("simul_mask_clr", 32'(mask), 0);
    check("simul_flags_clr", 32'({special_mask, read_isr, rotate_aeoi}), 0);
    check("simul_init0", 32'(init_done), 0);
    tick();

    // ICW1 during WAIT_ICW4 restarts
    wr(S_ICW2, 8'h20); tick();
    wr(S_OCW1, 8'h3C); tick();
    check("wait4_ocw_ignored", 32'(mask), 0);
    wr(S_ICW1, 8'h19); tick();
    check("restart_ltim", 32'(ltim), 1);
    wr(S_ICW4, 8'h02); tick();
    check("restart_icw4_drop", 32'({init_done, aeoi}), 0);
    wr(S_ICW2, 8'hF8); tick();
    check("restart_vb", 32'(vector_base), 32'h1F);
    check("restart_wait4", 32'(init_done), 0);
    wr(S_ICW4, 8'h02); tick();
    check("restart_ready", 32'({init_done, aeoi}), 3);

    // Reset from READY, strobe held across release registers as an edge
    wr(S_OCW1, 8'h5A); tick();
    reset = 0; internal_bus = 8'h13; write_ICW_1 = 1;
    tick();
    check("midreset_outs", 32'(all_outs()), 0);
    reset = 1;
    tick();
    write_ICW_1 = 0;
    check("post_reset_edge", 32'({init_done, sngl, ic4}), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
